// File: rtl/smart_led_pkg.sv
// Shared definitions for the smart LED PWM array: default sizes, the PWM
// period function and the channel slice helper.
package smart_led_pkg;

  localparam int DEFAULT_CHANNELS = 3;
  localparam int DEFAULT_WIDTH    = 10;

  // A WIDTH-bit duty spans 0..2^WIDTH-1, so the period is one tick shorter
  // than the counter range; an all-ones duty is then "always on".
  function automatic int pwm_period(input int width);
    return (1 << width) - 1;
  endfunction

  function automatic int chan_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/smart_led_pwm_channel.sv
// One PWM channel: shadow/active duty pair, fade stepping and output compare.
module smart_led_pwm_channel #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             wrap,
  input  logic             fade_en,
  input  logic [WIDTH-1:0] cnt_next,
  output logic             out,
  output logic             diff_next
);

  logic [WIDTH-1:0] shadow, shadow_next;
  logic [WIDTH-1:0] active, active_next;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    shadow_next = load ? data : shadow;
    active_next = active;
    // Commit reads the registered shadow, so a load on the wrap cycle waits a period.
    if (wrap) begin
      if (!fade_en)             active_next = shadow;
      else if (active < shadow) active_next = active + WIDTH'(1);
      else if (active > shadow) active_next = active - WIDTH'(1);
    end
    diff_next = (active_next != shadow_next);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
      active <= '0;
      out    <= 1'b0;
    end else begin
      shadow <= shadow_next;
      active <= active_next;
      out    <= (cnt_next < active_next);
    end
  end

endmodule

// File: rtl/smart_led_pwm_array.sv
// N-channel PWM generator: prescaler, phase counter, period boundary pulse
// and busy reduction, with one smart_led_pwm_channel per output.
module smart_led_pwm_array
  import smart_led_pkg::*;
#(
  parameter int CHANNELS = DEFAULT_CHANNELS,
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [CHANNELS*WIDTH-1:0] data,
  input  logic                      fade_en,
  output logic [CHANNELS-1:0]       out,
  output logic                      period_start,
  output logic                      busy
);

  localparam int               PERIOD   = pwm_period(WIDTH);
  localparam int               PS_W     = $clog2(PRESCALE + 1);
  localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(PERIOD - 1);

  logic [PS_W-1:0]     psc, psc_next;
  logic [WIDTH-1:0]    cnt, cnt_next;
  logic                tick, wrap;
  logic [CHANNELS-1:0] diff_next;

  always_comb begin
    tick     = (psc == PS_LAST);
    wrap     = tick && (cnt == CNT_LAST);
    psc_next = tick ? '0 : psc + PS_W'(1);
    cnt_next = cnt;
    if (wrap)      cnt_next = '0;
    else if (tick) cnt_next = cnt + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc          <= '0;
      cnt          <= '0;
      period_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      psc          <= psc_next;
      cnt          <= cnt_next;
      period_start <= wrap;
      busy         <= |diff_next;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    smart_led_pwm_channel #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .data      (data[chan_lsb(i, WIDTH) +: WIDTH]),
      .wrap      (wrap),
      .fade_en   (fade_en),
      .cnt_next  (cnt_next),
      .out       (out[i]),
      .diff_next (diff_next[i])
    );
  end

endmodule

// File: tb/tb_smart_led_pwm_array.sv
// Directed bench for smart_led_pwm_array (3 channels, WIDTH=4, P=15) with a
// second instance at PRESCALE=3 for the prescaler timing.
module tb_smart_led_pwm_array;

  localparam int P = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load, fade_en;
  logic [11:0] data;
  logic [2:0]  out;
  logic        period_start, busy;
  logic        load3, fade_en3;
  logic [11:0] data3;
  logic [2:0]  out3;
  logic        period_start3, busy3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  smart_led_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .data(data), .fade_en(fade_en),
    .out(out), .period_start(period_start), .busy(busy)
  );

  smart_led_pwm_array #(.CHANNELS(3), .WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(load3), .data(data3), .fade_en(fade_en3),
    .out(out3), .period_start(period_start3), .busy(busy3)
  );

  typedef struct {
    logic [3:0] d2, d1, d0;
    int         e2, e1, e0;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic wait_ps(input int budget);
    for (int i = 0; i < budget && !period_start; i++) @(negedge clk);
    if (!period_start) check("period_start_timeout", period_start, 1);
  endtask

  task automatic wait_ps3(input int budget);
    for (int i = 0; i < budget && !period_start3; i++) @(negedge clk);
    if (!period_start3) check("period_start3_timeout", period_start3, 1);
  endtask

  task automatic do_load(input logic [11:0] d);
    data = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Called at the negedge where period_start is high; returns at the next one.
  task automatic count_period(output int c0, output int c1, output int c2);
    c0 = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < P; i++) begin
      c0 += int'(out[0]);
      c1 += int'(out[1]);
      c2 += int'(out[2]);
      @(negedge clk);
    end
  endtask

  initial begin
    vec_t vecs[4];
    int   c0, c1, c2, n, hi;
    int   fade_up[4]   = '{1, 2, 3, 3};
    int   busy_up[4]   = '{1, 1, 0, 0};
    int   fade_down[3] = '{2, 1, 0};
    bit   found;

    vecs[0] = '{d2: 4'd15, d1: 4'd0,  d0: 4'd5, e2: 15, e1: 0,  e0: 5};
    vecs[1] = '{d2: 4'd1,  d1: 4'd14, d0: 4'd8, e2: 1,  e1: 14, e0: 8};
    vecs[2] = '{d2: 4'd0,  d1: 4'd15, d0: 4'd3, e2: 0,  e1: 15, e0: 3};
    vecs[3] = '{d2: 4'd7,  d1: 4'd7,  d0: 4'd0, e2: 7,  e1: 7,  e0: 0};

    rst_n = 1'b0; load = 1'b0; fade_en = 1'b0; data = '0;
    load3 = 1'b0; fade_en3 = 1'b0; data3 = '0;
    #12;
    check("reset_out", int'(out), 0);
    check("reset_period_start", int'(period_start), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_out3", int'(out3), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Jump mode table: load mid-period, new duties appear after the next wrap.
    for (int v = 0; v < 4; v++) begin
      wait_ps(40);
      do_load({vecs[v].d2, vecs[v].d1, vecs[v].d0});
      check($sformatf("vec%0d_busy_after_load", v), int'(busy), 1);
      wait_ps(40);
      check($sformatf("vec%0d_busy_after_wrap", v), int'(busy), 0);
      count_period(c0, c1, c2);
      check($sformatf("vec%0d_ch0_high", v), c0, vecs[v].e0);
      check($sformatf("vec%0d_ch1_high", v), c1, vecs[v].e1);
      check($sformatf("vec%0d_ch2_high", v), c2, vecs[v].e2);
    end

    // Load on the exact wrap cycle: old shadow commits, new one a period later.
    wait_ps(40);
    do_load(12'h002);
    wait_ps(40);
    repeat (P - 1) @(negedge clk);
    do_load(12'h007);
    check("wrapload_period_start", int'(period_start), 1);
    count_period(c0, c1, c2);
    check("wrapload_first_period", c0, 2);
    count_period(c0, c1, c2);
    check("wrapload_second_period", c0, 7);

    // Fade up from 0 to 3.
    do_load(12'h000);
    wait_ps(40);
    fade_en = 1'b1;
    do_load(12'h003);
    wait_ps(40);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("fade_up%0d_busy", k), int'(busy), busy_up[k]);
      count_period(c0, c1, c2);
      check($sformatf("fade_up%0d_high", k), c0, fade_up[k]);
    end

    // Fade down from 3 to 0.
    do_load(12'h000);
    wait_ps(40);
    for (int k = 0; k < 3; k++) begin
      count_period(c0, c1, c2);
      check($sformatf("fade_down%0d_high", k), c0, fade_down[k]);
    end
    check("fade_down_busy", int'(busy), 0);

    // fade_en toggled mid-period: only its value at the wrap matters.
    do_load(12'h006);
    wait_ps(40);
    hi = 0;
    for (int i = 0; i < P; i++) begin
      hi += int'(out[0]);
      if (i == 5)  fade_en = 1'b0;
      if (i == 8)  fade_en = 1'b1;
      if (i == 12) fade_en = 1'b0;
      @(negedge clk);
    end
    check("fade_toggle_period_a", hi, 1);
    check("fade_toggle_period_start", int'(period_start), 1);
    count_period(c0, c1, c2);
    check("fade_toggle_jump", c0, 6);
    check("fade_toggle_busy", int'(busy), 0);

    // Asynchronous reset mid-period with out high and busy set.
    do_load(12'h009);
    @(negedge clk);
    check("pre_reset_out0", int'(out[0]), 1);
    check("pre_reset_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_out", int'(out), 0);
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_period_start", int'(period_start), 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; hi = 0; found = 1'b0;
    for (int k = 1; k <= 40 && !found; k++) begin
      @(negedge clk);
      if (period_start) begin
        found = 1'b1;
        n = k;
      end else begin
        hi += int'(out != 3'b000);
      end
    end
    check("post_reset_first_period_start", n, P);
    check("post_reset_out_high_cycles", hi, 0);
    check("post_reset_busy", int'(busy), 0);

    // PRESCALE=3: 45-cycle periods, duty 1 is high for 3 clk cycles.
    data3 = 12'h001;
    load3 = 1'b1;
    @(negedge clk);
    load3 = 1'b0;
    wait_ps3(100);
    @(negedge clk);
    wait_ps3(100);
    n = 0; hi = 0;
    do begin
      hi += int'(out3[0]);
      @(negedge clk);
      n++;
    end while (!period_start3 && n < 100);
    check("prescale_period_cycles", n, 45);
    check("prescale_high_cycles", hi, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/smart_led_pwm_array.md
Name: smart_led_pwm_array

Overview:
- Parametrised successor to the fixed 3-channel 10-bit LED PWM.
- N-channel PWM generator with configurable resolution and prescaler.
- Double-buffered duty registers commit only at period boundaries, so outputs never glitch.
- Optional fade mode ramps each channel toward its target by one step per period.
- Sits after the protocol serial2parallel stage: it takes its parallel word plus the store strobe and drives the LED pins.

Parameters:
- CHANNELS, 3, number of PWM outputs.
- WIDTH, 10, duty resolution in bits; PWM period P = 2^WIDTH-1 ticks.
- PRESCALE, 1, clk cycles per PWM tick (>=1); the prescaler counter is $clog2(PRESCALE+1) bits wide.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  single-cycle strobe; captures data into the shadow registers.
- data  input  CHANNELS*WIDTH  target duties; channel i = data[i*WIDTH +: WIDTH].
- fade_en  input  1  0 = jump mode, 1 = fade mode; sampled at each period boundary.
- out  output  CHANNELS  registered PWM outputs.
- period_start  output  1  registered one-cycle pulse in the first cycle of each period.
- busy  output  1  high while any active duty differs from its shadow.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: out=0, period_start=0, busy=0, all shadow and active duties=0, tick counter=0, phase counter cnt=0.
- Tick generation: a tick occurs when the prescaler reaches PRESCALE-1, then the prescaler wraps to 0. With PRESCALE=1, every cycle is a tick.
- Phase counter: cnt advances 0..P-1 on ticks. On a tick with cnt==P-1 (the wrap event), cnt returns to 0.
- Commit at wrap event, per channel i:
  - Jump mode: active[i] <= shadow[i].
  - Fade mode: active[i] moves one toward shadow[i] (+1 or -1); no change if equal.
- Load: shadow <= data on the cycle load=1.
- Load on the same cycle as a wrap: the commit uses the old shadow value; the new data takes effect at the next wrap.
- Output compare: out[i] is registered as (cnt_next < active_next[i]). Outputs switch on the same clock edge as the counter and commit, so the first period after a commit already uses the new duty.
- Duty range:
  - duty 0 keeps the output constantly 0.
  - duty all-ones (=P) keeps it constantly 1 with no one-tick gap.
  - duty d gives exactly d high ticks per period.
- period_start: high in the cycle where cnt has just become 0 after a wrap. It first asserts P ticks after reset release, since cnt starts at 0 without a pulse.
- busy: registered, equal to OR over i of (active[i] != shadow[i]), evaluated after each update.
  - In jump mode, busy clears at the next wrap.
  - In fade mode it can stay high for up to P periods.
- fade_en changing mid-period has no effect until the next wrap.
- Reset mid-operation: everything returns to reset values immediately (asynchronous); no partial period completes.
- Arithmetic: fade steps saturate inherently because stepping stops at equality; no wrap-around.
- Comparisons are unsigned, WIDTH bits.

Decomposition:
- Shared package smart_led_pkg:
  - default WIDTH and CHANNELS;
  - function pwm_period(width) = 2^width-1;
  - localparam-style channel slice helper.
- One sub-module, smart_led_pwm_channel, instantiated CHANNELS times via generate. It holds shadow and active registers, fade step logic, and the output compare.
- The top level owns the prescaler, phase counter, wrap, period_start and the busy reduction.

Test Plan (CHANNELS=3, WIDTH=4 so P=15, PRESCALE=1 unless noted):
- Reset, then load data={ch2=15, ch1=0, ch0=5} in jump mode.
  - After the next wrap: out[2] constantly 1, out[1] constantly 0, out[0] high exactly 5 of every 15 cycles starting at period_start.
  - busy=1 until that wrap, then 0.
- PRESCALE=3, ch0=1: period_start spacing is 45 clk cycles; out[0] is high for exactly 3 cycles per period.
- Load asserted on the exact wrap cycle with ch0=7 after a previous ch0=2: the following period shows 2 high ticks and the next shows 7.
- Fade mode, ch0 active=0, load ch0=3: high counts over successive periods are 1, 2, 3, 3. busy drops after the third wrap.
- Fade down from 3 to 0 in fade mode: high counts 2, 1, 0. Toggle fade_en mid-period: the mode change applies only from the next wrap.
- Assert rst_n low mid-period with out high: out, busy and period_start go 0 immediately without waiting for clk. After release, the counter restarts at 0 with duties 0.
